led_sequencer_param: RTL and testbench
======================================

// Module: led_sequencer_param
// PURPOSE
//  Second-generation LED pattern sequencer. Replaces the derived-clock divider plus fixed 8-LED sequencer pair.
//  - Uses a single clock domain with a clock-enable tick divider (no generated clocks).
//  - LED count is parametrised; eight patterns; run/pause control.
//  - Pattern changes are applied glitch-free on a step boundary; a sequence-wrap pulse marks each complete pass.
//  - Sits directly behind the top-level pins: board 10 MHz clock in, LED bank out.
// PARAMETERS
//  NUM_LEDS  8           number of LED outputs, 2..32
//  BASE_DIV  10_000_000  clocks per step at rate_sel=0 (1 Hz at 10 MHz); must be >= 64
//  DIV_W     24          divider counter width; must satisfy 2**DIV_W > BASE_DIV
// PORTS
//  clk_10MHz    in   1         system clock, 10 MHz
//  rstn         in   1         asynchronous, active-low reset
//  rate_sel     in   2         step period = BASE_DIV >> (2*rate_sel) clocks (1/4/16/64 Hz nominal)
//  pattern_sel  in   3         requested pattern, 0..7
//  run          in   1         1 = sequence advances; 0 = pause (divider and state hold)
//  brightness   in   4         PWM duty; ignored unless LED_PWM_EN is defined
//  led_out      out  NUM_LEDS  LED drive, 1 = on
//  seq_wrap     out  1         one-clock pulse on the step that completes a pattern pass
// BEHAVIOUR
//  Reset (async, rstn=0):
//   - div_cnt=0, pat_cur=0, step=0, dir=0, led_out=0, seq_wrap=0.
//   - Release is synchronous to clk_10MHz.
//  Divider:
//   - period P = BASE_DIV >> (2*rate_sel), recomputed every cycle.
//   - When run=1: tick when div_cnt >= P-1, then div_cnt<=0; otherwise div_cnt++.
//   - The >= compare is mandatory: a rate_sel change to a shorter P ticks on the next cycle, never via DIV_W wrap-around.
//   - When run=0: div_cnt, step, led_out hold; seq_wrap=0.
//  Tick edge (all updates occur on the same clock edge):
//   - If pattern_sel != pat_cur:
//     - pat_cur<=pattern_sel, step<=0, dir<=0.
//     - led_out<=decode(new pattern, step 0); seq_wrap=0.
//   - Else: step advances per pattern; led_out<=decode(next state).
//   - seq_wrap=1 for that one cycle if the pass completes.
//   - pattern_sel is sampled only at tick edges; changes between ticks have no effect.
//  Patterns (N=NUM_LEDS, k=step):
//   - 0 all off; 1 all on (k unused, no seq_wrap).
//   - 2 walk left: 1<<k, k 0..N-1, wrap N-1->0.
//   - 3 walk right: 1<<(N-1-k), k 0..N-1, wrap N-1->0.
//   - 4 bounce: 1<<k; k 0..N-1..0, dir flips at k=N-1 and k=0.
//     - pass = 2N-2 steps; wrap on the step arriving at k=0.
//   - 5 alternate: k parity p; led = p ? ~A : A, where A has even bits set (0x55 for N=8); wrap on p 1->0.
//   - 6 binary count: k mod 2**N; wrap on all-ones -> 0.
//   - 7 fill/drain: k 0..2N-1.
//     - k<N: low k+1 bits set; else low 2N-1-k bits set.
//     - wrap 2N-1->0.
//  Latency: led_out changes on the tick edge itself; no extra pipeline stage.
//  Reset mid-operation: immediate async clear to reset values; the sequence restarts at pattern 0.
// CONFIGURATION
//  LED_PWM_EN defined:
//   - 4-bit pwm_cnt free-runs whenever rstn=1, independent of run.
//   - Registered pwm_on = (brightness==15) | (pwm_cnt < brightness).
//   - led_out = led_reg & {NUM_LEDS{pwm_on}}, one pwm_cnt period = 16 clocks.
//   - brightness=0 gives dark LEDs.
//   - seq_wrap and sequencing are unaffected.
//  LED_PWM_EN undefined: brightness is unused; led_out = led_reg; no PWM logic is synthesised.
// TESTING (sim with BASE_DIV=64, NUM_LEDS=8)
//  1. rstn=0 with pattern_sel=2 -> led_out=0x00, seq_wrap=0.
//     Release -> first tick 64 clocks later gives 0x01, then 0x02..0x80, 0x01.
//     seq_wrap pulses exactly on the 0x80->0x01 edge.
//  2. pattern_sel=4, rate_sel=3 (P=1) -> led_out 0x01,0x02..0x80,0x40..0x01 on consecutive clocks.
//     seq_wrap on each return to 0x01 (every 14 steps).
//  3. rate_sel 0->2 while div_cnt=40 -> tick on the next clock, then every 4 clocks.
//     No 2**DIV_W-long gap.
//  4. Walk at 0x08, run=0 for 200 clocks -> led_out stays 0x08, no seq_wrap.
//     run=1 -> 0x10 after the remaining div_cnt count.
//  5. At 0x08 switch pattern_sel 2->7 mid-period -> led_out stays 0x08 until the tick, then 0x01, 0x03..0xFF, 0x7F..0x00.
//     seq_wrap only on 0x00->0x01; none at the switch.
//  6. pattern 1, brightness=4: LED_PWM_EN defined -> 0xFF for 4 of every 16 clocks, else 0x00.
//     brightness=15 -> 0xFF always. Macro undefined -> constant 0xFF.

Source files
------------

// File: rtl/led_sequencer_param.sv
// Parametrised LED pattern sequencer: single clock domain, clock-enable step divider,
// eight patterns with run/pause. Optional PWM dimming is enabled by defining LED_PWM_EN.
module led_sequencer_param #(
    parameter int NUM_LEDS = 8,
    parameter int BASE_DIV = 10_000_000,
    parameter int DIV_W    = 24
) (
    input  logic                clk_10MHz,
    input  logic                rstn,
    input  logic [1:0]          rate_sel,
    input  logic [2:0]          pattern_sel,
    input  logic                run,
    input  logic [3:0]          brightness,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                seq_wrap
);
    // One spare bit so fill/drain can count to 2N-1 for every legal NUM_LEDS.
    localparam int STEP_W = NUM_LEDS + 1;
    localparam logic [DIV_W-1:0]  BASE_P    = DIV_W'(BASE_DIV);
    localparam logic [STEP_W-1:0] ONE_K     = STEP_W'(1);
    localparam logic [STEP_W-1:0] LAST_K    = STEP_W'(NUM_LEDS - 1);
    localparam logic [STEP_W-1:0] LAST_FILL = STEP_W'(2 * NUM_LEDS - 1);
    localparam logic [STEP_W-1:0] CNT_MASK  = {1'b0, {NUM_LEDS{1'b1}}};

    logic [DIV_W-1:0]    div_cnt_q;
    logic [2:0]          pat_cur_q;
    logic [STEP_W-1:0]   step_q;
    logic                dir_q;
    logic [NUM_LEDS-1:0] led_q;
    logic                wrap_q;

    logic [DIV_W-1:0]    period_s;
    logic [DIV_W-1:0]    period_m1_s;
    logic                tick_s;
    logic [STEP_W-1:0]   step_d;
    logic                dir_d;
    logic                wrap_d;

    function automatic logic [NUM_LEDS-1:0] decode(input logic [2:0] pat, input logic [STEP_W-1:0] k);
        logic [NUM_LEDS-1:0] v;
        logic [STEP_W-1:0]   fill_n;
        v      = '0;
        fill_n = (k < STEP_W'(NUM_LEDS)) ? (k + ONE_K) : (LAST_FILL - k);
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (pat)
                3'd0:    v[i] = 1'b0;
                3'd1:    v[i] = 1'b1;
                3'd2:    v[i] = (k == STEP_W'(i));
                3'd3:    v[i] = (k == STEP_W'(NUM_LEDS - 1 - i));
                3'd4:    v[i] = (k == STEP_W'(i));
                3'd5:    v[i] = ((i % 2) == 0) ^ k[0];
                3'd6:    v[i] = k[i];
                3'd7:    v[i] = (STEP_W'(i) < fill_n);
                default: v[i] = 1'b0;
            endcase
        end
        return v;
    endfunction

    // Step period and tick; >= lets a shortened period fire at once instead of wrapping.
    always_comb begin
        period_s    = BASE_P >> {rate_sel, 1'b0};
        period_m1_s = period_s - DIV_W'(1);
        tick_s      = run && (div_cnt_q >= period_m1_s);
    end

    // Next step/direction/wrap for the current pattern.
    always_comb begin
        step_d = step_q;
        dir_d  = dir_q;
        wrap_d = 1'b0;
        case (pat_cur_q)
            3'd2, 3'd3: begin
                if (step_q >= LAST_K) begin
                    step_d = '0;
                    wrap_d = 1'b1;
                end else begin
                    step_d = step_q + ONE_K;
                end
            end
            3'd4: begin
                if (!dir_q) begin
                    step_d = step_q + ONE_K;
                    if (step_q + ONE_K >= LAST_K) begin
                        dir_d = 1'b1;
                    end else begin
                        dir_d = 1'b0;
                    end
                end else begin
                    step_d = step_q - ONE_K;
                    if (step_q <= ONE_K) begin
                        dir_d  = 1'b0;
                        wrap_d = 1'b1;
                    end else begin
                        dir_d  = 1'b1;
                    end
                end
            end
            3'd5: begin
                step_d = step_q[0] ? '0 : ONE_K;
                wrap_d = step_q[0];
            end
            3'd6: begin
                step_d = (step_q + ONE_K) & CNT_MASK;
                wrap_d = (step_q[NUM_LEDS-1:0] == {NUM_LEDS{1'b1}});
            end
            3'd7: begin
                if (step_q >= LAST_FILL) begin
                    step_d = '0;
                    wrap_d = 1'b1;
                end else begin
                    step_d = step_q + ONE_K;
                end
            end
            default: begin
                step_d = step_q;
                wrap_d = 1'b0;
            end
        endcase
    end

    // Divider and sequencer state; a pattern change restarts at step 0 on the tick.
    always_ff @(posedge clk_10MHz or negedge rstn) begin
        if (!rstn) begin
            div_cnt_q <= '0;
            pat_cur_q <= 3'd0;
            step_q    <= '0;
            dir_q     <= 1'b0;
            led_q     <= '0;
            wrap_q    <= 1'b0;
        end else if (!run) begin
            wrap_q    <= 1'b0;
        end else if (tick_s) begin
            div_cnt_q <= '0;
            if (pattern_sel != pat_cur_q) begin
                pat_cur_q <= pattern_sel;
                step_q    <= '0;
                dir_q     <= 1'b0;
                led_q     <= decode(pattern_sel, '0);
                wrap_q    <= 1'b0;
            end else begin
                step_q    <= step_d;
                dir_q     <= dir_d;
                led_q     <= decode(pat_cur_q, step_d);
                wrap_q    <= wrap_d;
            end
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
            wrap_q    <= 1'b0;
        end
    end

    assign seq_wrap = wrap_q;

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt_q;
    logic       pwm_on_q;

    // Free-running 16-clock PWM frame; full scale forces the LEDs fully on.
    always_ff @(posedge clk_10MHz or negedge rstn) begin
        if (!rstn) begin
            pwm_cnt_q <= 4'd0;
            pwm_on_q  <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 4'd1;
            pwm_on_q  <= (brightness == 4'd15) | (pwm_cnt_q < brightness);
        end
    end

    assign led_out = led_q & {NUM_LEDS{pwm_on_q}};
`else
    logic unused_brightness_s;
    assign unused_brightness_s = ^brightness;
    assign led_out = led_q;
`endif

endmodule

// File: tb/tb_led_sequencer_param.sv
// Directed bench for led_sequencer_param with BASE_DIV=64, NUM_LEDS=8.
module tb_led_sequencer_param;
    logic       clk;
    logic       rstn;
    logic [1:0] rate_sel;
    logic [2:0] pattern_sel;
    logic       run;
    logic [3:0] brightness;
    logic [7:0] led_out;
    logic       seq_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    led_sequencer_param #(.NUM_LEDS(8), .BASE_DIV(64), .DIV_W(24)) dut (
        .clk_10MHz   (clk),
        .rstn        (rstn),
        .rate_sel    (rate_sel),
        .pattern_sel (pattern_sel),
        .run         (run),
        .brightness  (brightness),
        .led_out     (led_out),
        .seq_wrap    (seq_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] fill7 [16] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h7F,
                               8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h01};
    logic [3:0] bright_tab [3] = '{4'd4, 4'd15, 4'd0};

    initial begin
        int hold_ok;
        int k;
        int on_cnt;
        int bad_cnt;
        int wrap_cnt;
        int exp_on;

        rstn = 1'b0; rate_sel = 2'd0; pattern_sel = 3'd2; run = 1'b1; brightness = 4'd15;
        clk_n(3);
        chk("rst_led", 32'(led_out), 32'h00);
        chk("rst_wrap", 32'(seq_wrap), 32'h0);

        // Walk left at P=64
        rstn = 1'b1;
        clk_n(63);
        chk("walk_pre_tick", 32'(led_out), 32'h00);
        clk_n(1);
        chk("walk_first", 32'(led_out), 32'h01);
        chk("walk_first_wrap", 32'(seq_wrap), 32'h0);
        for (int i = 1; i < 8; i++) begin
            clk_n(64);
            chk("walk_step", 32'(led_out), 32'd1 << i);
            chk("walk_step_wrap", 32'(seq_wrap), 32'h0);
        end
        clk_n(64);
        chk("walk_wrap_led", 32'(led_out), 32'h01);
        chk("walk_wrap_pulse", 32'(seq_wrap), 32'h1);
        clk_n(1);
        chk("walk_wrap_end", 32'(seq_wrap), 32'h0);

        // Pause at 0x08
        clk_n(191);
        chk("pause_at8", 32'(led_out), 32'h08);
        clk_n(10);
        run = 1'b0;
        hold_ok = 1;
        for (int i = 0; i < 200; i++) begin
            clk_n(1);
            if (led_out !== 8'h08 || seq_wrap !== 1'b0) hold_ok = 0;
        end
        chk("pause_hold", 32'(hold_ok), 32'd1);
        run = 1'b1;
        clk_n(53);
        chk("resume_pre", 32'(led_out), 32'h08);
        clk_n(1);
        chk("resume_tick", 32'(led_out), 32'h10);

        // Pattern change mid-period to fill/drain
        clk_n(20);
        pattern_sel = 3'd7;
        clk_n(43);
        chk("switch_pre", 32'(led_out), 32'h10);
        clk_n(1);
        chk("switch_led", 32'(led_out), 32'h01);
        chk("switch_wrap", 32'(seq_wrap), 32'h0);
        rate_sel = 2'd3;
        for (int j = 0; j < 16; j++) begin
            clk_n(1);
            chk("fill_led", 32'(led_out), 32'(fill7[j]));
            chk("fill_wrap", 32'(seq_wrap), (j == 15) ? 32'h1 : 32'h0);
        end

        // Bounce at P=1
        pattern_sel = 3'd4;
        clk_n(1);
        chk("bounce_start", 32'(led_out), 32'h01);
        chk("bounce_start_wrap", 32'(seq_wrap), 32'h0);
        for (int j = 1; j <= 14; j++) begin
            clk_n(1);
            k = (j <= 7) ? j : 14 - j;
            chk("bounce_led", 32'(led_out), 32'd1 << k);
            chk("bounce_wrap", 32'(seq_wrap), (j == 14) ? 32'h1 : 32'h0);
        end
        clk_n(1);
        chk("bounce_next", 32'(led_out), 32'h02);
        chk("bounce_next_wrap", 32'(seq_wrap), 32'h0);

        // Rate shortened while div_cnt=40
        rate_sel = 2'd0;
        pattern_sel = 3'd2;
        clk_n(40);
        chk("rate_pre", 32'(led_out), 32'h02);
        rate_sel = 2'd2;
        clk_n(1);
        chk("rate_immediate", 32'(led_out), 32'h01);
        clk_n(3);
        chk("rate_hold1", 32'(led_out), 32'h01);
        clk_n(1);
        chk("rate_p4_a", 32'(led_out), 32'h02);
        clk_n(3);
        chk("rate_hold2", 32'(led_out), 32'h02);
        clk_n(1);
        chk("rate_p4_b", 32'(led_out), 32'h04);

        // Asynchronous reset mid-operation
        rstn = 1'b0;
        #2;
        chk("async_rst_led", 32'(led_out), 32'h00);
        chk("async_rst_wrap", 32'(seq_wrap), 32'h0);
        rate_sel = 2'd3;
        clk_n(1);
        rstn = 1'b1;
        clk_n(1);
        chk("restart_led", 32'(led_out), 32'h01);
        clk_n(1);
        chk("restart_next", 32'(led_out), 32'h02);

        // All-on pattern and brightness
        pattern_sel = 3'd1;
        clk_n(1);
        chk("allon_led", 32'(led_out), 32'hFF);
        for (int b = 0; b < 3; b++) begin
            brightness = bright_tab[b];
            clk_n(2);
            on_cnt = 0; bad_cnt = 0; wrap_cnt = 0;
            for (int c = 0; c < 16; c++) begin
                clk_n(1);
                if (led_out === 8'hFF) on_cnt++;
                else if (led_out !== 8'h00) bad_cnt++;
                if (seq_wrap !== 1'b0) wrap_cnt++;
            end
`ifdef LED_PWM_EN
            exp_on = (bright_tab[b] == 4'd15) ? 16 : int'(bright_tab[b]);
`else
            exp_on = 16;
`endif
            chk("pwm_on_cycles", 32'(on_cnt), 32'(exp_on));
            chk("pwm_bad_levels", 32'(bad_cnt), 32'd0);
            chk("pwm_no_wrap", 32'(wrap_cnt), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
